ram_arb_2to1: RTL and testbench
===============================

Name: ram_arb_2to1

Overview:
- Two-requester arbiter/sequencer in front of a single-port 32x64 synchronous SRAM macro.
- Macro controls are active-low: cen=0 enables an access; wen=0 writes, wen=1 reads. Read data is valid one clock after the read edge.
- Used in the debug AXI/UART path so the UART command engine (requester 0) and the AXI slave (requester 1) share one RAM.
- Fair round-robin with optional bounded lock; zero added request latency, one-cycle read return.

Parameters:
- AW, 5, RAM address width (32 words).
- DW, 64, RAM data width.
- LOCK_MAX, 8, maximum consecutive grants to a locked requester before a forced switch (1..255).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  access request (valid).
- we0, we1  in  1  1=write, 0=read; qualified by reqN.
- lock0, lock1  in  1  ask to keep the grant next cycle.
- addr0, addr1  in  AW  word address.
- wdata0, wdata1  in  DW  write data.
- ready0, ready1  out  1  request accepted this cycle; transfer completes when reqN && readyN.
- rvalid0, rvalid1  out  1  read data valid on rdataN.
- rdata0, rdata1  out  DW  read data; 0 when rvalidN=0.
- ram_cen  out  1  to RAM cen, active low.
- ram_wen  out  1  to RAM wen, active low.
- ram_addr  out  AW  to RAM addr.
- ram_din  out  DW  to RAM din.
- ram_dout  in  DW  from RAM dout.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low. All state flops clear on rst_n low.
- Reset state and outputs:
  - last=1, so requester 0 wins the first tie.
  - lock_cnt=0, locked=0, rd_pend=0, rd_owner=0.
  - While rst_n=0: ram_cen=1, ram_wen=1, ram_addr=0, ram_din=0, ready0/1=0, rvalid0/1=0, rdata0/1=0.
- Arbitration is combinational within the cycle. RAM controls and readyN are driven in the same cycle as the request, so there is no added latency.
  - Only one requester active: it is granted.
  - Both requesting, not locked: grant the requester that is not `last`.
  - Locked to N with reqN=1: grant N regardless of the other requester.
- Grant to N drives:
  - readyN=1.
  - ram_cen=0, ram_wen=~weN, ram_addr=addrN.
  - ram_din=wdataN on write, 0 on read.
- No grant: ram_cen=1, ram_wen=1, ram_addr=0, ram_din=0. Idle inputs are never X toward the RAM.
- Registered on each grant:
  - last <= N.
  - If weN=0: rd_pend <= 1, rd_owner <= N; otherwise rd_pend <= 0.
  - No grant: rd_pend <= 0.
- Read return:
  - rvalid[rd_owner] = rd_pend, i.e. exactly one cycle after the accepted read.
  - rdata[rd_owner] = ram_dout while its rvalid is high; the other rdata is 0.
  - Back-to-back reads by any mix of requesters return in acceptance order, one per cycle.
- Write-then-read of the same address on consecutive cycles returns the new data; no bypass is needed.
- Lock counter:
  - Grant to N with lockN=1: locked <= 1, owner <= N, lock_cnt <= lock_cnt+1.
  - Lock is released and lock_cnt <= 0 when any of the following holds:
    - lockN=0 on a granted cycle;
    - reqN=0;
    - lock_cnt reaches LOCK_MAX-1 (forced release).
  - On a forced release: if the other requester is requesting, it gets the next cycle even if lockN is still 1.
  - lock_cnt saturates and never wraps.
- A lock held by a requester that has dropped req has no effect; arbitration returns to round-robin in the same cycle.
- Simultaneous read by one requester and write by the other: only the granted op occurs. The loser sees ready=0 and must hold req, we, addr and wdata stable until ready.
- Reset mid-operation: a pending read return is discarded (rvalid forced 0) and lock state is cleared.

Test Plan:
- Reset, then req0 write addr=3 wdata=64'hDEAD_BEEF_0000_0001, then req0 read addr=3 → ready0=1 on both cycles. Write cycle: ram_cen=0, ram_wen=0. Read cycle: ram_cen=0, ram_wen=1. Next cycle: rvalid0=1, rdata0=64'hDEAD_BEEF_0000_0001; rdata1=0.
- req0 and req1 reads held high together for 6 cycles (addrs 1, 2) → grants alternate 0,1,0,1,0,1, starting with 0 after reset. rvalid alternates one cycle later with matching data. No cycle has both ready0 and ready1 high.
- LOCK_MAX=4, req0+lock0 held high, req1 high → grants 0,0,0,0,1,0,0,0,0,1,…; ready1 is never starved beyond 4 cycles.
- req1 writes addr=31; next cycle req0 reads addr=31 → rvalid0 one cycle later carries the new data (wrap/top address check).
- Assert rst_n=0 in the cycle after an accepted read → rvalid stays 0 and ram_cen=1 immediately. After release, requester 0 wins the first tie.
- No requests for 10 cycles → ram_cen=1, ram_wen=1, ram_addr=0, ram_din=0 with no X on any output.

Source files
------------

// File: rtl/ram_arb_2to1_if.sv
// Request/response and RAM macro signals shared by the 2:1 RAM arbiter.
// The slave view is the arbiter's; the master view belongs to the requesters and the RAM.
interface ram_arb_2to1_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 64
);
  logic          req0, req1;
  logic          we0, we1;
  logic          lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ready0, ready1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_cen;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, ram_dout,
    output ready0, ready1, rvalid0, rvalid1, rdata0, rdata1,
    output ram_cen, ram_wen, ram_addr, ram_din
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, ram_dout,
    input  ready0, ready1, rvalid0, rvalid1, rdata0, rdata1,
    input  ram_cen, ram_wen, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_arb_2to1.sv
// Round-robin 2:1 arbiter with bounded lock in front of a single-port synchronous SRAM.
// Grants and RAM controls are combinational from the requests; read data returns one cycle later.
module ram_arb_2to1 #(
  parameter int unsigned AW       = 5,
  parameter int unsigned DW       = 64,
  parameter int unsigned LOCK_MAX = 8
) (
  input logic           clk,
  input logic           rst_n,
  ram_arb_2to1_if.slave bus
);
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  logic          last;
  logic          locked;
  logic          owner;
  logic [CW-1:0] lock_cnt;
  logic          rd_pend;
  logic          rd_owner;

  logic          lock_act;
  logic          gnt_any;
  logic          gnt_sel;
  logic          gnt_we;
  logic          gnt_lock;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;
  logic [CW-1:0] cnt_eff;

  // Grant selection: an active lock wins, otherwise round-robin on ties
  always_comb begin
    lock_act  = 1'b0;
    gnt_any   = 1'b0;
    gnt_sel   = 1'b0;
    gnt_we    = 1'b0;
    gnt_lock  = 1'b0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    cnt_eff   = '0;

    lock_act = locked && (owner ? bus.req1 : bus.req0);
    gnt_any  = rst_n && (bus.req0 || bus.req1);
    if (lock_act)                  gnt_sel = owner;
    else if (bus.req0 && bus.req1) gnt_sel = ~last;
    else                           gnt_sel = bus.req1;

    gnt_we    = gnt_sel ? bus.we1    : bus.we0;
    gnt_lock  = gnt_sel ? bus.lock1  : bus.lock0;
    gnt_addr  = gnt_sel ? bus.addr1  : bus.addr0;
    gnt_wdata = gnt_sel ? bus.wdata1 : bus.wdata0;
    // A lock run continues only for the requester that already owns it
    cnt_eff   = (locked && (owner == gnt_sel)) ? lock_cnt : '0;
  end

  assign bus.ready0   = gnt_any && !gnt_sel;
  assign bus.ready1   = gnt_any &&  gnt_sel;
  assign bus.ram_cen  = ~gnt_any;
  assign bus.ram_wen  = ~(gnt_any && gnt_we);
  assign bus.ram_addr = gnt_any ? gnt_addr : '0;
  assign bus.ram_din  = (gnt_any && gnt_we) ? gnt_wdata : '0;

  assign bus.rvalid0  = rd_pend && !rd_owner;
  assign bus.rvalid1  = rd_pend &&  rd_owner;
  assign bus.rdata0   = bus.rvalid0 ? bus.ram_dout : '0;
  assign bus.rdata1   = bus.rvalid1 ? bus.ram_dout : '0;

  // Arbitration history, lock run tracking and read-return bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 1'b1;
      locked   <= 1'b0;
      owner    <= 1'b0;
      lock_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= gnt_any && !gnt_we;
      if (gnt_any) begin
        last <= gnt_sel;
        if (!gnt_we) rd_owner <= gnt_sel;
      end
      // The grant that brings the count to its limit releases the lock
      if (gnt_any && gnt_lock && (cnt_eff < CNT_LAST)) begin
        locked   <= 1'b1;
        owner    <= gnt_sel;
        lock_cnt <= cnt_eff + CW'(1);
      end else begin
        locked   <= 1'b0;
        lock_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ram_arb_2to1.sv
// Directed bench for ram_arb_2to1 with a behavioural 32x64 SRAM model.
module tb_ram_arb_2to1;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 64;
  localparam int unsigned LOCK_MAX = 4;
  localparam logic [DW-1:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [DW-1:0] D2 = 64'h5555_6666_7777_8888;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ram_arb_2to1_if #(.AW(AW), .DW(DW)) bus();

  ram_arb_2to1 #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [32];
  logic [DW-1:0] dout_q = '0;

  always @(posedge clk) begin
    if (!bus.ram_cen) begin
      if (!bus.ram_wen) mem[bus.ram_addr] <= bus.ram_din;
      else              dout_q <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_dout = dout_q;

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.lock0 = 0; bus.lock1 = 0; bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 5'd3; bus.wdata0 = 64'h5; bus.req1 = 1;
    @(negedge clk);
    checks++;
    if ({bus.ready0, bus.ready1, bus.rvalid0, bus.rvalid1, bus.ram_cen, bus.ram_wen} !== 6'b000011) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000011",
        {bus.ready0, bus.ready1, bus.rvalid0, bus.rvalid1, bus.ram_cen, bus.ram_wen});
    end
    checks++;
    if ({bus.ram_addr, bus.ram_din} !== '0) begin
      failures++;
      $display("FAIL reset_addr_din got addr=%h din=%h want 0", bus.ram_addr, bus.ram_din);
    end
    checks++;
    if ({bus.rdata0, bus.rdata1} !== '0) begin
      failures++;
      $display("FAIL reset_rdata got %h/%h want 0", bus.rdata0, bus.rdata1);
    end
    do_reset();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] wd;
    wd = 64'hDEAD_BEEF_0000_0001;
    do_reset();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 5'd3; bus.wdata0 = wd;
    @(negedge clk);
    checks++;
    if ({bus.ready0, bus.ready1, bus.ram_cen, bus.ram_wen} !== 4'b1000) begin
      failures++;
      $display("FAIL wr_ctrl got=%b want=1000", {bus.ready0, bus.ready1, bus.ram_cen, bus.ram_wen});
    end
    checks++;
    if (bus.ram_addr !== 5'd3 || bus.ram_din !== wd) begin
      failures++;
      $display("FAIL wr_bus got addr=%0d din=%h want addr=3 din=%h", bus.ram_addr, bus.ram_din, wd);
    end
    @(posedge clk); #1;
    bus.we0 = 0;
    @(negedge clk);
    checks++;
    if ({bus.ready0, bus.ready1, bus.ram_cen, bus.ram_wen} !== 4'b1001) begin
      failures++;
      $display("FAIL rd_ctrl got=%b want=1001", {bus.ready0, bus.ready1, bus.ram_cen, bus.ram_wen});
    end
    checks++;
    if (bus.ram_addr !== 5'd3 || bus.ram_din !== '0) begin
      failures++;
      $display("FAIL rd_bus got addr=%0d din=%h want addr=3 din=0", bus.ram_addr, bus.ram_din);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b10 || bus.rdata0 !== wd || bus.rdata1 !== '0) begin
      failures++;
      $display("FAIL rd_return got rv=%b d0=%h d1=%h want rv=10 d0=%h d1=0",
        {bus.rvalid0, bus.rvalid1}, bus.rdata0, bus.rdata1, wd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        bus.req0 = 1; bus.addr0 = 5'd1; bus.req1 = 1; bus.addr1 = 5'd2;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (i < 6) begin
        checks++;
        if ({bus.ready0, bus.ready1} !== ((i % 2 == 1) ? 2'b01 : 2'b10)) begin
          failures++;
          $display("FAIL rr_grant cyc=%0d got=%b want=%b", i, {bus.ready0, bus.ready1},
            (i % 2 == 1) ? 2'b01 : 2'b10);
        end
      end
      if (i > 0) begin
        checks++;
        if ((i - 1) % 2 == 1) begin
          if ({bus.rvalid0, bus.rvalid1} !== 2'b01 || bus.rdata0 !== '0 || bus.rdata1 !== D2) begin
            failures++;
            $display("FAIL rr_return cyc=%0d got rv=%b d0=%h d1=%h want rv=01 d1=%h",
              i, {bus.rvalid0, bus.rvalid1}, bus.rdata0, bus.rdata1, D2);
          end
        end else begin
          if ({bus.rvalid0, bus.rvalid1} !== 2'b10 || bus.rdata0 !== D1 || bus.rdata1 !== '0) begin
            failures++;
            $display("FAIL rr_return cyc=%0d got rv=%b d0=%h d1=%h want rv=10 d0=%h",
              i, {bus.rvalid0, bus.rvalid1}, bus.rdata0, bus.rdata1, D1);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock();
    logic [9:0] exp_g;
    exp_g = 10'b10_0001_0000;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.req0 = 1; bus.lock0 = 1; bus.addr0 = 5'd1; bus.req1 = 1; bus.addr1 = 5'd2;
      @(negedge clk);
      checks++;
      if ({bus.ready0, bus.ready1} !== (exp_g[i] ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL lock_grant cyc=%0d got=%b want=%b", i, {bus.ready0, bus.ready1},
          exp_g[i] ? 2'b01 : 2'b10);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_top_addr();
    logic [DW-1:0] wd;
    wd = 64'hCAFE_F00D_1234_5678;
    do_reset();
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 5'd31; bus.wdata1 = wd;
    @(negedge clk);
    checks++;
    if ({bus.ready0, bus.ready1, bus.ram_wen} !== 3'b010 || bus.ram_addr !== 5'd31) begin
      failures++;
      $display("FAIL top_wr got rdy=%b wen=%b addr=%0d want rdy=01 wen=0 addr=31",
        {bus.ready0, bus.ready1}, bus.ram_wen, bus.ram_addr);
    end
    @(posedge clk); #1;
    idle_inputs();
    bus.req0 = 1; bus.addr0 = 5'd31;
    @(negedge clk);
    checks++;
    if ({bus.ready0, bus.ready1, bus.ram_wen} !== 3'b101 || bus.ram_addr !== 5'd31) begin
      failures++;
      $display("FAIL top_rd got rdy=%b wen=%b addr=%0d want rdy=10 wen=1 addr=31",
        {bus.ready0, bus.ready1}, bus.ram_wen, bus.ram_addr);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== wd) begin
      failures++;
      $display("FAIL top_return got rv0=%b d0=%h want rv0=1 d0=%h", bus.rvalid0, bus.rdata0, wd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req0 = 1; bus.addr0 = 5'd1;
    @(negedge clk);
    checks++;
    if (bus.ready0 !== 1'b1) begin
      failures++;
      $display("FAIL mid_accept got ready0=%b want 1", bus.ready0);
    end
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({bus.rvalid0, bus.rvalid1, bus.ready0, bus.ram_cen} !== 4'b0001 || bus.rdata0 !== '0) begin
      failures++;
      $display("FAIL mid_reset got rv=%b rdy0=%b cen=%b d0=%h want rv=00 rdy0=0 cen=1 d0=0",
        {bus.rvalid0, bus.rvalid1}, bus.ready0, bus.ram_cen, bus.rdata0);
    end
    @(posedge clk); #1;
    rst_n = 1;
    bus.req1 = 1; bus.addr1 = 5'd2;
    @(negedge clk);
    checks++;
    if ({bus.ready0, bus.ready1} !== 2'b10) begin
      failures++;
      $display("FAIL mid_first_tie got=%b want=10", {bus.ready0, bus.ready1});
    end
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    do_reset();
    bus.we0 = 1; bus.addr0 = 5'd7; bus.wdata0 = '1; bus.addr1 = 5'd9; bus.lock1 = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.ram_cen, bus.ram_wen, bus.ram_addr, bus.ram_din} !== {1'b1, 1'b1, 5'd0, 64'd0} ||
          {bus.ready0, bus.ready1, bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1} !== '0) begin
        failures++;
        $display("FAIL idle cyc=%0d got cen=%b wen=%b addr=%0d din=%h rdy=%b rv=%b",
          i, bus.ram_cen, bus.ram_wen, bus.ram_addr, bus.ram_din,
          {bus.ready0, bus.ready1}, {bus.rvalid0, bus.rvalid1});
      end
      checks++;
      if ($isunknown({bus.ram_cen, bus.ram_wen, bus.ram_addr, bus.ram_din, bus.ready0, bus.ready1,
                      bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1})) begin
        failures++;
        $display("FAIL idle_x cyc=%0d got X on an output want none", i);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 64'(i);
    mem[1] = D1;
    mem[2] = D2;
    idle_inputs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock();
    test_top_addr();
    test_reset_mid();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
